// File: rtl/aludec_stage_if.sv
// Handshake and result bundle between the ID stage, the ALU-control decode stage and EX.
// The slave modport is the decode stage; the master modport is its surrounding pipeline.
interface aludec_stage_if #(
    parameter int INSTR_W = 32,
    parameter int CTRL_W  = 5
);
    logic [INSTR_W-1:0] instrD;
    logic               in_valid;
    logic               in_ready;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [CTRL_W-1:0]  alucontrol_o;
    logic               muldiv_o;
    logic               hilo_rd_o;
    logic               hilo_wr_o;
    logic               illegal_o;
    logic               muldiv_busy_o;

    modport slave (
        input  instrD, in_valid, flush, out_ready,
        output in_ready, out_valid, alucontrol_o, muldiv_o,
               hilo_rd_o, hilo_wr_o, illegal_o, muldiv_busy_o
    );

    modport master (
        output instrD, in_valid, flush, out_ready,
        input  in_ready, out_valid, alucontrol_o, muldiv_o,
               hilo_rd_o, hilo_wr_o, illegal_o, muldiv_busy_o
    );
endinterface

// File: rtl/aludec_stage.sv
// Registered ALU-control decode stage (ID->EX) with a mul/div busy tracker.
// Optional macro ALUDEC_ARITH_EN adds ADD/ADDU/SUB/SUBU/SLT/SLTU (R and I forms).
module aludec_stage #(
    parameter int INSTR_W = 32,
    parameter int CTRL_W  = 5,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 36,
    parameter int CNT_W   = 6
) (
    input  logic            clk,
    input  logic            rst,
    aludec_stage_if.slave   bus
);
    localparam logic [CTRL_W-1:0] SIG_ALU_AND   = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] SIG_ALU_OR    = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] SIG_ALU_XOR   = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] SIG_ALU_NOR   = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] SIG_ALU_LUI   = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] SIG_ALU_SLL   = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] SIG_ALU_SRL   = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] SIG_ALU_SRA   = CTRL_W'(8);
    localparam logic [CTRL_W-1:0] SIG_ALU_SLLV  = CTRL_W'(9);
    localparam logic [CTRL_W-1:0] SIG_ALU_SRLV  = CTRL_W'(10);
    localparam logic [CTRL_W-1:0] SIG_ALU_SRAV  = CTRL_W'(11);
    localparam logic [CTRL_W-1:0] SIG_ALU_MFHI  = CTRL_W'(12);
    localparam logic [CTRL_W-1:0] SIG_ALU_MFLO  = CTRL_W'(13);
    localparam logic [CTRL_W-1:0] SIG_ALU_MTHI  = CTRL_W'(14);
    localparam logic [CTRL_W-1:0] SIG_ALU_MTLO  = CTRL_W'(15);
    localparam logic [CTRL_W-1:0] SIG_ALU_MULT  = CTRL_W'(16);
    localparam logic [CTRL_W-1:0] SIG_ALU_MULTU = CTRL_W'(17);
    localparam logic [CTRL_W-1:0] SIG_ALU_DIV   = CTRL_W'(18);
    localparam logic [CTRL_W-1:0] SIG_ALU_DIVU  = CTRL_W'(19);
`ifdef ALUDEC_ARITH_EN
    localparam logic [CTRL_W-1:0] SIG_ALU_ADD   = CTRL_W'(20);
    localparam logic [CTRL_W-1:0] SIG_ALU_ADDU  = CTRL_W'(21);
    localparam logic [CTRL_W-1:0] SIG_ALU_SUB   = CTRL_W'(22);
    localparam logic [CTRL_W-1:0] SIG_ALU_SUBU  = CTRL_W'(23);
    localparam logic [CTRL_W-1:0] SIG_ALU_SLT   = CTRL_W'(24);
    localparam logic [CTRL_W-1:0] SIG_ALU_SLTU  = CTRL_W'(25);
`endif
    localparam logic [CTRL_W-1:0] SIG_ALU_FAIL  = CTRL_W'(31);

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_muldiv, dec_hilo_rd, dec_hilo_wr, dec_illegal;
    logic              hazard, accept, handoff;

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              muldiv_q, hilo_rd_q, hilo_wr_q, illegal_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.instrD[INSTR_W-7:6];

    assign op    = bus.instrD[INSTR_W-1 -: 6];
    assign funct = bus.instrD[5:0];

    always_comb begin
        dec_ctrl = SIG_ALU_FAIL;
        if (op == 6'h00) begin
            case (funct)
                6'h24: dec_ctrl = SIG_ALU_AND;
                6'h25: dec_ctrl = SIG_ALU_OR;
                6'h26: dec_ctrl = SIG_ALU_XOR;
                6'h27: dec_ctrl = SIG_ALU_NOR;
                6'h00: dec_ctrl = SIG_ALU_SLL;
                6'h02: dec_ctrl = SIG_ALU_SRL;
                6'h03: dec_ctrl = SIG_ALU_SRA;
                6'h04: dec_ctrl = SIG_ALU_SLLV;
                6'h06: dec_ctrl = SIG_ALU_SRLV;
                6'h07: dec_ctrl = SIG_ALU_SRAV;
                6'h10: dec_ctrl = SIG_ALU_MFHI;
                6'h11: dec_ctrl = SIG_ALU_MTHI;
                6'h12: dec_ctrl = SIG_ALU_MFLO;
                6'h13: dec_ctrl = SIG_ALU_MTLO;
                6'h18: dec_ctrl = SIG_ALU_MULT;
                6'h19: dec_ctrl = SIG_ALU_MULTU;
                6'h1A: dec_ctrl = SIG_ALU_DIV;
                6'h1B: dec_ctrl = SIG_ALU_DIVU;
`ifdef ALUDEC_ARITH_EN
                6'h20: dec_ctrl = SIG_ALU_ADD;
                6'h21: dec_ctrl = SIG_ALU_ADDU;
                6'h22: dec_ctrl = SIG_ALU_SUB;
                6'h23: dec_ctrl = SIG_ALU_SUBU;
                6'h2A: dec_ctrl = SIG_ALU_SLT;
                6'h2B: dec_ctrl = SIG_ALU_SLTU;
`endif
                default: dec_ctrl = SIG_ALU_FAIL;
            endcase
        end else begin
            case (op)
                6'h0C: dec_ctrl = SIG_ALU_AND;
                6'h0D: dec_ctrl = SIG_ALU_OR;
                6'h0E: dec_ctrl = SIG_ALU_XOR;
                6'h0F: dec_ctrl = SIG_ALU_LUI;
`ifdef ALUDEC_ARITH_EN
                6'h08: dec_ctrl = SIG_ALU_ADD;
                6'h09: dec_ctrl = SIG_ALU_ADDU;
                6'h0A: dec_ctrl = SIG_ALU_SLT;
                6'h0B: dec_ctrl = SIG_ALU_SLTU;
`endif
                default: dec_ctrl = SIG_ALU_FAIL;
            endcase
        end
    end

    assign dec_illegal = (dec_ctrl == SIG_ALU_FAIL);
    assign dec_muldiv  = (dec_ctrl == SIG_ALU_MULT) || (dec_ctrl == SIG_ALU_MULTU) ||
                         (dec_ctrl == SIG_ALU_DIV)  || (dec_ctrl == SIG_ALU_DIVU);
    assign dec_hilo_rd = (dec_ctrl == SIG_ALU_MFHI) || (dec_ctrl == SIG_ALU_MFLO);
    assign dec_hilo_wr = dec_muldiv || (dec_ctrl == SIG_ALU_MTHI) || (dec_ctrl == SIG_ALU_MTLO);

    // A held mul/div counts as busy: it will start the unit as soon as EX takes it.
    assign hazard  = (dec_hilo_rd || dec_hilo_wr) && ((cnt_q != '0) || (valid_q && muldiv_q));
    assign bus.in_ready = !bus.flush && !hazard && (!valid_q || bus.out_ready);
    assign accept  = bus.in_valid && bus.in_ready;
    assign handoff = valid_q && bus.out_ready && !bus.flush && muldiv_q;

    always_comb begin
        cnt_d = cnt_q;
        if (handoff) begin
            cnt_d = ((ctrl_q == SIG_ALU_DIV) || (ctrl_q == SIG_ALU_DIVU)) ?
                    CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            muldiv_q  <= 1'b0;
            hilo_rd_q <= 1'b0;
            hilo_wr_q <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (bus.flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q   <= 1'b1;
                ctrl_q    <= dec_ctrl;
                muldiv_q  <= dec_muldiv;
                hilo_rd_q <= dec_hilo_rd;
                hilo_wr_q <= dec_hilo_wr;
                illegal_q <= dec_illegal;
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid     = valid_q;
    assign bus.alucontrol_o  = ctrl_q;
    assign bus.muldiv_o      = muldiv_q;
    assign bus.hilo_rd_o     = hilo_rd_q;
    assign bus.hilo_wr_o     = hilo_wr_q;
    assign bus.illegal_o     = illegal_q;
    assign bus.muldiv_busy_o = (cnt_q != '0);
endmodule

// File: tb/tb_aludec_stage.sv
// Scoreboard bench for aludec_stage: the driver queues expected decodes on acceptance,
// the monitor pops and compares each entry EX takes, and flushed entries are dropped.
module tb_aludec_stage;
    localparam int DIV_LAT = 36;
    localparam int MUL_LAT = 2;

    localparam logic [4:0] C_AND  = 5'd1;
    localparam logic [4:0] C_OR   = 5'd2;
    localparam logic [4:0] C_XOR  = 5'd3;
    localparam logic [4:0] C_NOR  = 5'd4;
    localparam logic [4:0] C_LUI  = 5'd5;
    localparam logic [4:0] C_SRA  = 5'd8;
    localparam logic [4:0] C_MFHI = 5'd12;
    localparam logic [4:0] C_MFLO = 5'd13;
    localparam logic [4:0] C_MTHI = 5'd14;
    localparam logic [4:0] C_MULT = 5'd16;
    localparam logic [4:0] C_DIV  = 5'd18;
    localparam logic [4:0] C_ADD  = 5'd20;
    localparam logic [4:0] C_FAIL = 5'd31;

    typedef struct packed {
        logic [4:0] ctrl;
        logic       muldiv;
        logic       hilo_rd;
        logic       hilo_wr;
        logic       illegal;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    aludec_stage_if #(.INSTR_W(32), .CTRL_W(5)) bus ();

    aludec_stage #(
        .INSTR_W(32), .CTRL_W(5), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Present one instruction until accepted; report stalled cycles and busy cycles seen.
    task automatic send(input logic [31:0] instr, input exp_t e,
                        output int waits, output int busy_seen);
        waits = 0;
        busy_seen = 0;
        bus.instrD   = instr;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb_q.push_back(e);
                break;
            end
            waits++;
            if (bus.muldiv_busy_o) busy_seen++;
            if (waits > 300) begin
                chk("accept_timeout", 32'(waits), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Monitor: compare each entry that EX takes; a flushed entry leaves the scoreboard unchecked.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (bus.flush) begin
                if (sb_q.size() != 0) void'(sb_q.pop_front());
            end else if (bus.out_ready) begin
                exp_t e;
                exp_t a;
                a = '{bus.alucontrol_o, bus.muldiv_o, bus.hilo_rd_o, bus.hilo_wr_o, bus.illegal_o};
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h, expected no entry", a);
                end else begin
                    e = sb_q.pop_front();
                    $display("xact t=%0t ctrl=%0d md=%0b rd=%0b wr=%0b ill=%0b",
                             $time, a.ctrl, a.muldiv, a.hilo_rd, a.hilo_wr, a.illegal);
                    chk("entry", 32'(a), 32'(e));
                end
            end
        end
    end

    initial begin
        int w, b;
        rst = 1'b1;
        bus.instrD = '0;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ctrl", 32'(bus.alucontrol_o), 32'd0);
        chk("rst_flags", 32'({bus.muldiv_o, bus.hilo_rd_o, bus.hilo_wr_o, bus.illegal_o}), 32'd0);
        chk("rst_busy", 32'(bus.muldiv_busy_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic decodes; AND/ORI/LUI back to back with no stall
        send(32'h00851024, '{C_AND, 1'b0, 1'b0, 1'b0, 1'b0}, w, b);
        chk("and_wait", 32'(w), 32'd0);
        send(32'h34420001, '{C_OR, 1'b0, 1'b0, 1'b0, 1'b0}, w, b);
        chk("ori_wait", 32'(w), 32'd0);
        send(32'h3C011234, '{C_LUI, 1'b0, 1'b0, 1'b0, 1'b0}, w, b);
        chk("lui_wait", 32'(w), 32'd0);
        send(32'h00851027, '{C_NOR, 1'b0, 1'b0, 1'b0, 1'b0}, w, b);
        send(32'h00051043, '{C_SRA, 1'b0, 1'b0, 1'b0, 1'b0}, w, b);
        send(32'h00800011, '{C_MTHI, 1'b0, 1'b0, 1'b1, 1'b0}, w, b);
        chk("mthi_wait", 32'(w), 32'd0);
        send(32'h8C820004, '{C_FAIL, 1'b0, 1'b0, 1'b0, 1'b1}, w, b);
`ifdef ALUDEC_ARITH_EN
        send(32'h00000020, '{C_ADD, 1'b0, 1'b0, 1'b0, 1'b0}, w, b);
`else
        send(32'h00000020, '{C_FAIL, 1'b0, 1'b0, 1'b0, 1'b1}, w, b);
`endif

        // MULT then MFHI: one stall while MULT is held, then MUL_LAT busy cycles
        send(32'h00850018, '{C_MULT, 1'b1, 1'b0, 1'b1, 1'b0}, w, b);
        send(32'h00001010, '{C_MFHI, 1'b0, 1'b1, 1'b0, 1'b0}, w, b);
        chk("mfhi_busy_cycles", 32'(b), 32'(MUL_LAT));
        chk("mfhi_stall_cycles", 32'(w), 32'(MUL_LAT + 1));

        // DIV then MFLO
        send(32'h0085001A, '{C_DIV, 1'b1, 1'b0, 1'b1, 1'b0}, w, b);
        send(32'h00001012, '{C_MFLO, 1'b0, 1'b1, 1'b0, 1'b0}, w, b);
        chk("mflo_busy_cycles", 32'(b), 32'(DIV_LAT));
        chk("mflo_stall_cycles", 32'(w), 32'(DIV_LAT + 1));
        repeat (2) @(posedge clk);
        #1;

        // Hold with out_ready=0 for 5 cycles, then flush with a competing input
        bus.out_ready = 1'b0;
        send(32'h00851026, '{C_XOR, 1'b0, 1'b0, 1'b0, 1'b0}, w, b);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_ctrl", 32'(bus.alucontrol_o), 32'(C_XOR));
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.instrD = 32'h34420001;
        @(negedge clk);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);

        // A flushed MULT must not start the busy counter
        @(posedge clk);
        #1;
        send(32'h00850018, '{C_MULT, 1'b1, 1'b0, 1'b1, 1'b0}, w, b);
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flushed_mult_busy", 32'(bus.muldiv_busy_o), 32'd0);
        chk("flushed_mult_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a divide, with an entry held
        send(32'h0085001A, '{C_DIV, 1'b1, 1'b0, 1'b1, 1'b0}, w, b);
        send(32'h00851024, '{C_AND, 1'b0, 1'b0, 1'b0, 1'b0}, w, b);
        bus.out_ready = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        chk("pre_rst_busy", 32'(bus.muldiv_busy_o), 32'd1);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_busy", 32'(bus.muldiv_busy_o), 32'd0);
        sb_q.delete();
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        send(32'h00001010, '{C_MFHI, 1'b0, 1'b1, 1'b0, 1'b0}, w, b);
        chk("post_rst_mfhi_wait", 32'(w), 32'd0);

        // Drain the scoreboard
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
